int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller; drives the core's interrupt inputs (int_req, int_en, int_vec).
- Collects up to 4 external interrupt lines, latches rising edges as pending and applies per-source masks.
- Fixed priority: lowest index highest. Issues one request at a time and blocks further requests until the core executes its return-from-interrupt.
- Configured by the core through a small register port decoded at top level.

Parameters:
- NUM_SRC, 4, number of interrupt sources (legal range 1..4).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_SRC  external interrupt lines; rising edge sets pending.
- iret  input  1  high for the one cycle the core executes its return instruction.
- reg_we  input  1  register write strobe.
- reg_addr  input  3  register select.
- reg_wdata  input  8  write data.
- reg_rdata  output  8  combinational read data for reg_addr.
- int_req  output  1  one-cycle request pulse to the core.
- int_en  output  8  bit0 = global interrupt enable (GIE); bits 7:1 tied 0.
- int_vec  output  8  handler address; valid whenever int_req=1.
- in_service  output  1  handler currently active.

Behaviour:
- Reset (synchronous, takes effect on the clock edge): GIE=0, MASK=0, PEND=0, all VECn=0, state IDLE, int_req=0, int_vec=0, in_service=0, edge history=0. A reset mid-service abandons the service and returns to IDLE.
- Register map:
  - 0 CTRL: bit0 GIE, rw.
  - 1 MASK: bits NUM_SRC-1:0, rw.
  - 2 PEND: read; write 1 to clear.
  - 3 STAT: read only; bit7 = in_service, bits 1:0 = active id.
  - 4..7 VEC0..VEC3: rw, 8 bits each.
  - Unused or unimplemented bits read 0. Writes to STAT and to VECn with n>=NUM_SRC are ignored.
- Edge detect: pend[i] is set when irq_q[i]=1 and irq_prev[i]=0.
  - irq_q is irq_in itself, or the synchronized copy (see Optional Feature).
  - If an edge set and a W1C clear hit the same bit in the same cycle, set wins.
- Arbitration: eligible = PEND & MASK. sel = lowest set index of eligible.
- FSM (state register, 2 bits):
  - IDLE -> REQ when GIE=1, eligible != 0, and no CTRL write is occurring this cycle (this avoids a request racing a GIE clear). On this edge:
    - int_vec <= VEC[sel]
    - active id <= sel
    - pend[sel] <= 0
    - int_req <= 1
  - REQ (exactly 1 cycle, int_req=1, int_en[0]=1 guaranteed) -> SERV; int_req <= 0.
  - SERV: in_service=1; no new request regardless of pending. iret=1 -> IDLE. New edges keep accumulating in PEND.
  - iret in IDLE or REQ is ignored.
  - Minimum spacing between two requests is 3 cycles: REQ, SERV (iret), IDLE re-arbitration.
- Latency: irq edge to int_req = 2 cycles without sync (edge registered into PEND, then IDLE->REQ); 4 cycles with sync.
- int_vec holds its last value outside REQ.
- Clearing MASK or GIE does not clear PEND.

Optional Feature:
- INT_CTRL_IRQ_SYNC_EN defined: irq_in passes through a 2-flop synchronizer per bit before edge detect (adds 2 cycles of latency; synchronizer flops reset to 0).
- Undefined: irq_in is assumed synchronous to clock and feeds edge detect directly.

Decomposition:
- Shared package int_ctrl_pkg:
  - register address constants ADDR_CTRL=0, ADDR_MASK=1, ADDR_PEND=2, ADDR_STAT=3, ADDR_VEC0=4.
  - FSM state encoding IDLE=0, REQ=1, SERV=2.
  - MAX_SRC=4.
- One natural sub-module: int_prio_enc (combinational lowest-index priority encoder producing sel and valid). Everything else stays in int_ctrl.

Test Plan:
- Basic request: VEC0=0x40, MASK=0x1, GIE=1; pulse irq_in[0] -> int_req high exactly one cycle with int_vec=0x40, PEND=0, STAT=0x80; iret -> STAT=0x00.
- Priority: VEC1=0x50, VEC2=0x60, MASK=0x6; raise irq_in[1] and irq_in[2] together -> first request int_vec=0x50; iret -> second request int_vec=0x60 three cycles after the first.
- Blocking and masking: edge on source 0 while in SERV -> no int_req until iret; edge on masked source 3 -> PEND bit 3 set, no request, until MASK bit 3 is set.
- GIE race: CTRL write 0x00 in the same cycle eligible becomes nonzero -> no int_req; PEND retained; re-enable GIE -> request issued.
- W1C vs edge collision: write PEND=0x1 in the same cycle a source-0 edge is detected -> PEND bit 0 remains 1.
- Reset mid-service: assert reset while in SERV with PEND=0x4 -> next cycle STAT=0, PEND=0, int_vec=0, int_req=0, GIE=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller: register map,
// FSM state encoding and the maximum source count.
package int_ctrl_pkg;

  localparam int MAX_SRC = 4;

  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd1;
  localparam logic [2:0] ADDR_PEND = 3'd2;
  localparam logic [2:0] ADDR_STAT = 3'd3;
  localparam logic [2:0] ADDR_VEC0 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder for up to MAX_SRC sources.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [1:0]         sel,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    sel   = '0;
    valid = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = 2'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, masking, fixed priority and
// a one-request-at-a-time FSM. Define INT_CTRL_IRQ_SYNC_EN to insert a 2-flop
// synchronizer on irq_in ahead of edge detection.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               iret,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               int_req,
  output logic [7:0]         int_en,
  output logic [7:0]         int_vec,
  output logic               in_service
);

  logic [NUM_SRC-1:0] irq_q, irq_prev, irq_rise;
  logic [NUM_SRC-1:0] mask, pend, pend_next, eligible;
  logic [7:0]         vec [MAX_SRC];
  logic               gie;
  logic [1:0]         active_id, sel;
  logic               valid, ctrl_wr, pend_wr, take;
  state_t             state;

`ifdef INT_CTRL_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_p0, sync_p1;

  // Synchronizer stage boundary: irq_in -> sync_p0 -> sync_p1.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_in;
      sync_p1 <= sync_p0;
    end
  end
  assign irq_q = sync_p1;
`else
  assign irq_q = irq_in;
`endif

  assign irq_rise = irq_q & ~irq_prev;
  assign eligible = pend & mask;
  assign ctrl_wr  = reg_we && (reg_addr == ADDR_CTRL);
  assign pend_wr  = reg_we && (reg_addr == ADDR_PEND);
  // A CTRL write in the arbitration cycle defers the request so a GIE clear wins.
  assign take     = (state == IDLE) && gie && valid && !ctrl_wr;
  assign int_en   = {7'b0, gie};

  int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (eligible),
    .sel   (sel),
    .valid (valid)
  );

  // New edges are OR-ed in last so they beat both W1C and the service clear.
  always_comb begin
    pend_next = pend;
    if (pend_wr) pend_next = pend_next & ~reg_wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take && (sel == 2'(i))) pend_next[i] = 1'b0;
    end
    pend_next = pend_next | irq_rise;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev <= '0;
      gie      <= 1'b0;
      mask     <= '0;
      pend     <= '0;
      for (int i = 0; i < MAX_SRC; i++) vec[i] <= '0;
    end else begin
      irq_prev <= irq_q;
      pend     <= pend_next;
      if (ctrl_wr) gie <= reg_wdata[0];
      if (reg_we && (reg_addr == ADDR_MASK)) mask <= reg_wdata[NUM_SRC-1:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (reg_we && (reg_addr == ADDR_VEC0 + 3'(i))) vec[i] <= reg_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      active_id  <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state     <= REQ;
            int_req   <= 1'b1;
            int_vec   <= vec[sel];
            active_id <= sel;
          end
        end
        REQ: begin
          state      <= SERV;
          int_req    <= 1'b0;
          in_service <= 1'b1;
        end
        SERV: begin
          if (iret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_CTRL: reg_rdata[0]           = gie;
      ADDR_MASK: reg_rdata[NUM_SRC-1:0] = mask;
      ADDR_PEND: reg_rdata[NUM_SRC-1:0] = pend;
      ADDR_STAT: reg_rdata              = {in_service, 5'b0, active_id};
      default:   reg_rdata              = vec[reg_addr[1:0]];
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (default NUM_SRC=4).
module tb_int_ctrl;
  import int_ctrl_pkg::*;

`ifdef INT_CTRL_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = '0;
  logic       iret = 1'b0;
  logic       reg_we = 1'b0;
  logic [2:0] reg_addr = '0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic       int_req;
  logic [7:0] int_en;
  logic [7:0] int_vec;
  logic       in_service;

  int tests_run = 0;
  int tests_failed = 0;

  int_ctrl #(.NUM_SRC(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .iret       (iret),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .int_req    (int_req),
    .int_en     (int_en),
    .int_vec    (int_vec),
    .in_service (in_service)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] addr, output logic [7:0] data);
    reg_addr = addr;
    #1;
    data = reg_rdata;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (int_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_service();
    tick();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  task automatic settle();
    irq_in = '0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reset_int_req got %b want 0", int_req); end
    tests_run++;
    if (int_vec !== 8'h00) begin tests_failed++; $display("FAIL reset_int_vec got %h want 00", int_vec); end
    tests_run++;
    if (int_en !== 8'h00) begin tests_failed++; $display("FAIL reset_int_en got %h want 00", int_en); end
    tests_run++;
    if (in_service !== 1'b0) begin tests_failed++; $display("FAIL reset_in_service got %b want 0", in_service); end
    read_reg(ADDR_MASK, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_mask got %h want 00", d); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_pend got %h want 00", d); end
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_stat got %h want 00", d); end
    read_reg(3'd7, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_vec3 got %h want 00", d); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int n;
    write_reg(ADDR_VEC0, 8'h40);
    write_reg(ADDR_MASK, 8'h01);
    write_reg(ADDR_CTRL, 8'h01);
    irq_in[0] = 1'b1;
    wait_req(n);
    tests_run++;
    if (n !== LAT) begin tests_failed++; $display("FAIL basic_latency got %0d want %0d", n, LAT); end
    tests_run++;
    if (int_vec !== 8'h40) begin tests_failed++; $display("FAIL basic_vec got %h want 40", int_vec); end
    tests_run++;
    if (int_en !== 8'h01) begin tests_failed++; $display("FAIL basic_int_en got %h want 01", int_en); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL basic_pend got %h want 00", d); end
    tick();
    tests_run++;
    if (int_req !== 1'b0) begin tests_failed++; $display("FAIL basic_req_one_cycle got %b want 0", int_req); end
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h80) begin tests_failed++; $display("FAIL basic_stat_serv got %h want 80", d); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL basic_stat_iret got %h want 00", d); end
    settle();
  endtask

  task automatic test_priority();
    logic [7:0] d;
    int n;
    write_reg(3'd5, 8'h50);
    write_reg(3'd6, 8'h60);
    write_reg(ADDR_MASK, 8'h06);
    irq_in = 4'b0110;
    wait_req(n);
    tests_run++;
    if (int_req !== 1'b1 || int_vec !== 8'h50) begin
      tests_failed++; $display("FAIL prio_first got req=%b vec=%h want req=1 vec=50", int_req, int_vec);
    end
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h01) begin tests_failed++; $display("FAIL prio_stat_req got %h want 01", d); end
    tick();
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h81) begin tests_failed++; $display("FAIL prio_stat_serv got %h want 81", d); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h04) begin tests_failed++; $display("FAIL prio_pend got %h want 04", d); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tests_run++;
    if (int_req !== 1'b0) begin tests_failed++; $display("FAIL prio_gap got req=%b want 0", int_req); end
    tick();
    tests_run++;
    if (int_req !== 1'b1 || int_vec !== 8'h60) begin
      tests_failed++; $display("FAIL prio_second got req=%b vec=%h want req=1 vec=60", int_req, int_vec);
    end
    finish_service();
    settle();
  endtask

  task automatic test_blocking();
    logic [7:0] d;
    int n;
    logic seen;
    write_reg(3'd7, 8'h70);
    write_reg(ADDR_MASK, 8'h01);
    irq_in[0] = 1'b1;
    wait_req(n);
    tick();
    irq_in[0] = 1'b0;
    tick();
    irq_in[0] = 1'b1;
    seen = 1'b0;
    repeat (LAT + 3) begin
      tick();
      if (int_req === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL block_serv got req seen=%b want 0", seen); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h01) begin tests_failed++; $display("FAIL block_pend got %h want 01", d); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    wait_req(n);
    tests_run++;
    if (n !== 1 || int_vec !== 8'h40) begin
      tests_failed++; $display("FAIL block_after_iret got n=%0d vec=%h want n=1 vec=40", n, int_vec);
    end
    finish_service();
    irq_in[3] = 1'b1;
    seen = 1'b0;
    repeat (LAT + 3) begin
      tick();
      if (int_req === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL mask_no_req got req seen=%b want 0", seen); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h08) begin tests_failed++; $display("FAIL mask_pend got %h want 08", d); end
    write_reg(ADDR_MASK, 8'h09);
    wait_req(n);
    tests_run++;
    if (n !== 1 || int_vec !== 8'h70) begin
      tests_failed++; $display("FAIL mask_enable got n=%0d vec=%h want n=1 vec=70", n, int_vec);
    end
    finish_service();
    settle();
  endtask

  task automatic test_gie_race();
    logic [7:0] d;
    int n;
    logic seen;
    irq_in[0] = 1'b1;
    repeat (LAT - 1) tick();
    write_reg(ADDR_CTRL, 8'h00);
    seen = int_req;
    repeat (3) begin
      tick();
      if (int_req === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL gie_race_req got %b want 0", seen); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h01) begin tests_failed++; $display("FAIL gie_race_pend got %h want 01", d); end
    tests_run++;
    if (int_en !== 8'h00) begin tests_failed++; $display("FAIL gie_race_int_en got %h want 00", int_en); end
    write_reg(ADDR_CTRL, 8'h01);
    wait_req(n);
    tests_run++;
    if (n !== 1 || int_vec !== 8'h40) begin
      tests_failed++; $display("FAIL gie_reenable got n=%0d vec=%h want n=1 vec=40", n, int_vec);
    end
    finish_service();
    settle();
  endtask

  task automatic test_w1c_collision();
    logic [7:0] d;
    write_reg(ADDR_CTRL, 8'h00);
    irq_in[0] = 1'b1;
    repeat (LAT - 2) tick();
    write_reg(ADDR_PEND, 8'h01);
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h01) begin tests_failed++; $display("FAIL w1c_collision got %h want 01", d); end
    write_reg(ADDR_PEND, 8'h01);
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL w1c_clear got %h want 00", d); end
    settle();
  endtask

  task automatic test_reset_mid_service();
    logic [7:0] d;
    int n;
    write_reg(ADDR_MASK, 8'h05);
    write_reg(ADDR_CTRL, 8'h01);
    irq_in[0] = 1'b1;
    wait_req(n);
    tick();
    irq_in[2] = 1'b1;
    repeat (LAT) tick();
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h04 || in_service !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_setup got pend=%h svc=%b want pend=04 svc=1", d, in_service);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_reg(ADDR_STAT, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_stat got %h want 00", d); end
    read_reg(ADDR_PEND, d);
    tests_run++;
    if (d !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_pend got %h want 00", d); end
    tests_run++;
    if (int_vec !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_vec got %h want 00", int_vec); end
    tests_run++;
    if (int_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_req got %b want 0", int_req); end
    read_reg(ADDR_CTRL, d);
    tests_run++;
    if (d !== 8'h00 || int_en !== 8'h00) begin
      tests_failed++; $display("FAIL rst_mid_gie got ctrl=%h int_en=%h want 00/00", d, int_en);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_blocking();
    test_gie_race();
    test_w1c_collision();
    test_reset_mid_service();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
